// File: rtl/connect4_pkg.sv
// Shared types and constants for the connect-four turn logic.
// Board defaults, FSM state type, winner codes and player type.
package connect4_pkg;

  localparam int COLS_DEF = 7;
  localparam int ROWS_DEF = 6;

  typedef enum logic [1:0] {
    S_SELECT,
    S_WRITE,
    S_CHECK,
    S_OVER
  } state_e;

  typedef logic player_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic [1:0] win_code(player_t p);
    return p ? WIN_P1 : WIN_P0;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Idle-turn counter; compiled only when TURN_TIMEOUT_EN is defined.
// Counts SELECT cycles without a pulse and fires one tick per timeout.
`ifdef TURN_TIMEOUT_EN
module turn_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o,
  output logic pulse_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          pulse_q;

  always_comb begin
    tick_o = run_i && !clr_i && (cnt_q == LAST);
    cnt_d  = cnt_q + 1'b1;
    // Held at zero outside SELECT so each turn starts fresh.
    if (!run_i || clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= tick_o;
    end
  end

  assign pulse_o = pulse_q;

endmodule
`endif

// File: rtl/turn_controller.sv
// Connect-four turn FSM: cursor, column heights, board writes, result.
// Define TURN_TIMEOUT_EN to forfeit idle turns via turn_timer.
module turn_controller
  import connect4_pkg::*;
#(
  parameter int COLS           = COLS_DEF,
  parameter int ROWS           = ROWS_DEF,
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        left_pulse,
  input  logic                        right_pulse,
  input  logic                        put_pulse,
  input  logic                        new_game,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [$clog2(ROWS+1)-1:0]   wr_row,
  output logic [$clog2(COLS)-1:0]     wr_col,
  output logic                        wr_player,
  input  logic                        check_done,
  input  logic                        win,
  output logic [$clog2(COLS)-1:0]     cursor_col,
  output logic                        player,
  output logic                        game_over,
  output logic [1:0]                  winner,
  output logic                        timeout_pulse
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS + 1);
  localparam int MW = $clog2(ROWS * COLS + 1);

  localparam logic [CW-1:0] MID  = CW'(COLS / 2);
  localparam logic [CW-1:0] LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] FULL = RW'(ROWS);
  localparam logic [MW-1:0] ALL  = MW'(ROWS * COLS);

  state_e        state_q, state_d;
  logic [CW-1:0] cur_q, cur_d;
  player_t       ply_q, ply_d;
  logic [RW-1:0] hgt_q [COLS];
  logic [RW-1:0] hgt_d [COLS];
  logic [MW-1:0] mv_q, mv_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  player_t       wply_q, wply_d;
  logic [1:0]    win_q, win_d;
  logic          to_tick;

`ifdef TURN_TIMEOUT_EN
  turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run_i  (state_q == S_SELECT),
    .clr_i  (left_pulse | right_pulse |
             put_pulse | new_game),
    .tick_o (to_tick),
    .pulse_o(timeout_pulse)
  );
`else
  assign to_tick       = 1'b0;
  assign timeout_pulse = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ply_d   = ply_q;
    hgt_d   = hgt_q;
    mv_d    = mv_q;
    row_d   = row_q;
    col_d   = col_q;
    wply_d  = wply_q;
    win_d   = win_q;
    if (new_game) begin
      state_d = S_SELECT;
      cur_d   = MID;
      ply_d   = 1'b0;
      for (int i = 0; i < COLS; i++) hgt_d[i] = '0;
      mv_d    = '0;
      row_d   = '0;
      col_d   = '0;
      wply_d  = 1'b0;
      win_d   = WIN_NONE;
    end else begin
      unique case (state_q)
        S_SELECT: begin
          if (put_pulse) begin
            if (hgt_q[cur_q] != FULL) begin
              state_d = S_WRITE;
              row_d   = hgt_q[cur_q];
              col_d   = cur_q;
              wply_d  = ply_q;
            end
          end else if (left_pulse && !right_pulse) begin
            cur_d = (cur_q == '0) ? LAST : cur_q - 1'b1;
          end else if (right_pulse && !left_pulse) begin
            cur_d = (cur_q == LAST) ? '0 : cur_q + 1'b1;
          end
          if (to_tick) ply_d = ~ply_q;
        end
        S_WRITE: begin
          if (wr_ready) begin
            hgt_d[col_q] = hgt_q[col_q] + 1'b1;
            mv_d         = mv_q + 1'b1;
            state_d      = S_CHECK;
          end
        end
        S_CHECK: begin
          if (check_done) begin
            if (win) begin
              win_d   = win_code(ply_q);
              state_d = S_OVER;
            end else if (mv_q == ALL) begin
              win_d   = WIN_DRAW;
              state_d = S_OVER;
            end else begin
              ply_d   = ~ply_q;
              state_d = S_SELECT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_SELECT;
      cur_q   <= MID;
      ply_q   <= 1'b0;
      for (int i = 0; i < COLS; i++) hgt_q[i] <= '0;
      mv_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wply_q  <= 1'b0;
      win_q   <= WIN_NONE;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ply_q   <= ply_d;
      hgt_q   <= hgt_d;
      mv_q    <= mv_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wply_q  <= wply_d;
      win_q   <= win_d;
    end
  end

  // Derived from state so reset drops the request asynchronously.
  assign wr_valid   = (state_q == S_WRITE);
  assign game_over  = (state_q == S_OVER);
  assign wr_row     = row_q;
  assign wr_col     = col_q;
  assign wr_player  = wply_q;
  assign cursor_col = cur_q;
  assign player     = ply_q;
  assign winner     = win_q;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: directed scenarios plus random play.
// Set TURN_TIMEOUT_EN to also model the idle-turn forfeit.
module tb_turn_controller;

  localparam int COLS = 7;
  localparam int ROWS = 6;
  localparam int TO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       left_pulse = 0, right_pulse = 0;
  logic       put_pulse = 0, new_game = 0;
  logic       wr_ready = 0, check_done = 0, win = 0;
  logic       wr_valid, wr_player, player;
  logic       game_over, timeout_pulse;
  logic [2:0] wr_row, wr_col, cursor_col;
  logic [1:0] winner;

  int n_vec = 0;
  int n_err = 0;

  turn_controller #(
    .COLS(COLS),
    .ROWS(ROWS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .left_pulse   (left_pulse),
    .right_pulse  (right_pulse),
    .put_pulse    (put_pulse),
    .new_game     (new_game),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_player    (wr_player),
    .check_done   (check_done),
    .win          (win),
    .cursor_col   (cursor_col),
    .player       (player),
    .game_over    (game_over),
    .winner       (winner),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: game described as board heights and turn flags.
  int m_h [COLS];
  int m_cur, m_mv, m_wrow, m_wcol, m_win, m_idle;
  bit m_ply, m_wply, m_wr, m_chk, m_over, m_tp;

  task automatic check(input string tag,
                       input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    foreach (m_h[i]) m_h[i] = 0;
    m_cur = COLS / 2; m_mv = 0;
    m_wrow = 0; m_wcol = 0; m_win = 0;
    m_idle = 0; m_ply = 0; m_wply = 0;
    m_wr = 0; m_chk = 0; m_over = 0; m_tp = 0;
  endtask

  task automatic mstep(input bit l, r, p, ng,
                       input bit rdy, cd, w);
    bit sel;
    sel  = !m_wr && !m_chk && !m_over;
    m_tp = 0;
    if (ng) begin
      mreset();
      return;
    end
    if (m_over) begin
    end else if (m_chk) begin
      if (cd) begin
        m_chk = 0;
        if (w) begin
          m_over = 1; m_win = m_ply ? 2 : 1;
        end else if (m_mv == ROWS * COLS) begin
          m_over = 1; m_win = 3;
        end else begin
          m_ply = !m_ply;
        end
      end
    end else if (m_wr) begin
      if (rdy) begin
        m_h[m_wcol]++; m_mv++;
        m_wr = 0; m_chk = 1;
      end
    end else if (p) begin
      if (m_h[m_cur] < ROWS) begin
        m_wr = 1; m_wrow = m_h[m_cur];
        m_wcol = m_cur; m_wply = m_ply;
      end
    end else if (l && !r) begin
      m_cur = (m_cur + COLS - 1) % COLS;
    end else if (r && !l) begin
      m_cur = (m_cur + 1) % COLS;
    end
`ifdef TURN_TIMEOUT_EN
    if (sel && !(l || r || p)) begin
      if (m_idle == TO - 1) begin
        m_idle = 0; m_ply = !m_ply; m_tp = 1;
      end else begin
        m_idle++;
      end
    end else begin
      m_idle = 0;
    end
`else
    if (sel) m_idle = 0;
`endif
  endtask

  task automatic check_all();
    check("wr_valid", wr_valid, m_wr);
    check("wr_row", wr_row, m_wrow);
    check("wr_col", wr_col, m_wcol);
    check("wr_player", wr_player, m_wply);
    check("cursor", cursor_col, m_cur);
    check("player", player, m_ply);
    check("game_over", game_over, m_over);
    check("winner", winner, m_win);
    check("timeout", timeout_pulse, m_tp);
  endtask

  // Called at a falling edge; applies inputs across one rising edge.
  task automatic cyc(input bit l, r, p, ng,
                     input bit rdy, cd, w);
    left_pulse = l; right_pulse = r;
    put_pulse = p; new_game = ng;
    wr_ready = rdy; check_done = cd; win = w;
    mstep(l, r, p, ng, rdy, cd, w);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle1();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic move(input bit w);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, w);
  endtask

  initial begin
    mreset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    check("rst_cursor", cursor_col, 3);
    rst = 1'b1;
    idle1();

    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    check("cur_r3", cursor_col, 6);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("cur_wrap_r", cursor_col, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("cur_wrap_l", cursor_col, 6);
    cyc(1, 1, 0, 0, 0, 0, 0);
    check("cur_both", cursor_col, 6);

    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    check("put_lat", wr_valid, 1);
    check("put_prio_cur", cursor_col, 3);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 1, 1);
    check("held_row", wr_row, 0);
    check("held_col", wr_col, 3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("wv_drop", wr_valid, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("p1_turn", player, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("stack_row", wr_row, 1);
    check("stack_ply", wr_player, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    cyc(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) move(0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("full_nowr", wr_valid, 0);
    check("full_ply", player, 0);

    cyc(0, 0, 0, 1, 0, 0, 0);
    move(0);
    move(1);
    check("win_over", game_over, 1);
    check("win_p1", winner, 2);
    cyc(1, 0, 1, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("ng_over", game_over, 0);

    for (int i = 0; i < ROWS * COLS; i++) begin
      move(0);
      if (i % ROWS == ROWS - 1) cyc(0, 1, 0, 0, 0, 0, 0);
    end
    check("draw_over", game_over, 1);
    check("draw_code", winner, 3);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("ng_write", wr_valid, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("ng_hgt", wr_row, 0);

    // Asynchronous reset while a write is pending.
    rst = 1'b0;
    #1;
    check("arst_wv", wr_valid, 0);
    mreset();
    @(negedge clk);
    rst = 1'b1;
    check_all();
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("arst_hgt", wr_row, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

`ifdef TURN_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) idle1();
    check("to_early", timeout_pulse, 0);
    idle1();
    check("to_fire", timeout_pulse, 1);
    for (int i = 0; i < 10; i++) idle1();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) idle1();
    check("to_restart", timeout_pulse, 0);
    idle1();
    check("to_fire2", timeout_pulse, 1);
`endif

    for (int n = 0; n < 6000; n++) begin
      cyc($urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 35,
          $urandom_range(0, 999) < 8,
          $urandom_range(0, 99) < 55,
          $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
